exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, 32'hBFC00380, exception entry PC.
REQ-002 Parameter FLUSH_CYCLES, 2, cycles flush_o is held (legal range 1..15).
REQ-003 Ports: clk  in  1  sole clock; rst  in  1  synchronous, active-high reset.
REQ-004 mem_valid_i  in  1  valid instruction in MEM stage.
REQ-005 syscall_i, break_i, overflow_i, adel_i, ades_i, eret_i  in  1 each  MEM-stage event flags, qualified by mem_valid_i.
REQ-006 delayslot_i  in  1  MEM instruction is in a delay slot; pc_i  in  32  MEM instruction PC.
REQ-007 status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC.
REQ-008 int_i  in  6  hardware interrupt lines; timer_int_i  in  1  CP0 timer interrupt.
REQ-009 redirect_ready_i  in  1  fetch stage accepts redirect.
REQ-010 exc_commit_o  out  1  one-cycle pulse: CP0 records exception.
REQ-011 exc_code_o  out  5  ExcCode for the commit; exc_delayslot_o  out  1; exc_pc_o  out  32  PC to record.
REQ-012 eret_commit_o  out  1  one-cycle pulse: CP0 clears Status.EXL.
REQ-013 flush_o  out  1  flush IF..MEM; busy_o  out  1  FSM not IDLE.
REQ-014 redirect_valid_o  out  1; redirect_pc_o  out  32  new fetch PC.

Function
REQ-015 Interrupt pending = |({int_i[5]|timer_int_i, int_i[4:0], cause_i[9:8]} & status_i[15:8]).
REQ-016 Interrupt is taken only when status_i[0]=1, status_i[1]=0, and mem_valid_i=1.
REQ-017 Priority, highest first: interrupt (code 0), AdEL (4), AdES (5), Ov (12), Sys (8), Bp (9), then eret.
REQ-018 FSM states: IDLE, FLUSH, REDIRECT.
REQ-019 In IDLE, a qualified event moves the FSM to FLUSH on the next edge; with no event it stays in IDLE.
REQ-020 Entry sampling: code, delayslot_i, pc_i, and target are captured; target is EXC_VECTOR for exceptions and epc_i for eret.
REQ-021 First FLUSH cycle: exactly one of exc_commit_o or eret_commit_o is 1 for one cycle, so latency is 1 cycle from event.
REQ-022 flush_o is 1 for exactly FLUSH_CYCLES cycles in FLUSH, counted by an internal down-counter; the FSM then enters REDIRECT.
REQ-023 In REDIRECT, redirect_valid_o=1 and redirect_pc_o=target, both held stable until redirect_ready_i=1; that edge returns the FSM to IDLE.
REQ-024 exc_pc_o = pc_i-4 when delayslot_i=1, else pc_i; the subtraction is modulo 2^32.
REQ-025 Events arriving while busy_o=1 are ignored and not queued, because the pipeline is being flushed.
REQ-026 When eret and an exception occur in the same cycle, the exception wins and eret is dropped.
REQ-027 When status_i[1]=1, synchronous exceptions are still taken and interrupts are masked.
REQ-028 Outputs are registered with no combinational path from inputs to outputs, except busy_o, which is decoded from state.

Reset
REQ-029 While rst=1 at an edge: state becomes IDLE and the counter is cleared; all outputs become 0, including redirect_pc_o and exc_pc_o.
REQ-030 A reset in any state, mid-flush or mid-redirect, aborts the operation with no commit pulse on the following cycle.

Structure
REQ-031 ExcCode constants (0,4,5,8,9,12) live in the shared header execode.v; CP0 Status/Cause bit positions live in sysreg.v.
REQ-032 FSM state encodings are local to exc_ctrl.
REQ-033 One combinational sub-module exc_prio_enc takes the flags and the interrupt-take signal and returns {valid, is_eret, code[4:0]}.

Verification
REQ-034 Syscall at pc_i=32'h80001000, delayslot_i=0 -> next cycle exc_commit_o=1, code 8, exc_pc_o=32'h80001000; flush_o for 2 cycles; redirect_pc_o=32'hBFC00380.
REQ-035 Overflow with delayslot_i=1, pc_i=32'h80002004 -> code 12, exc_delayslot_o=1, exc_pc_o=32'h80002000.
REQ-036 status_i=32'h0000FF01, timer_int_i=1, overflow_i=1 in the same cycle -> code 0 is taken; repeating with status_i[1]=1 -> code 12 is taken.
REQ-037 eret_i=1, epc_i=32'h80003008 -> eret_commit_o pulse, no exc_commit_o; redirect_pc_o=32'h80003008; with redirect_ready_i held low for 3 cycles, redirect_valid_o stays 1 for 4 cycles.
REQ-038 break_i during FLUSH is ignored; rst asserted during REDIRECT -> next cycle all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: ExcCode values, CP0
// Status/Cause bit positions and the priority encoder result type.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 9;

    typedef struct packed {
        logic       valid;
        logic       is_eret;
        logic [4:0] code;
    } exc_sel_t;

    // A delay-slot instruction records the PC of its branch.
    function automatic logic [31:0] exc_record_pc(input logic [31:0] pc, input logic ds);
        return ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selection of the MEM-stage event to commit.
// Inputs are expected to be already qualified by the MEM valid bit.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic     int_take_i,
    input  logic     adel_i,
    input  logic     ades_i,
    input  logic     overflow_i,
    input  logic     syscall_i,
    input  logic     break_i,
    input  logic     eret_i,
    output exc_sel_t sel_o
);

    always_comb begin
        sel_o       = '0;
        sel_o.valid = 1'b1;
        if (int_take_i)      sel_o.code = EXC_INT;
        else if (adel_i)     sel_o.code = EXC_ADEL;
        else if (ades_i)     sel_o.code = EXC_ADES;
        else if (overflow_i) sel_o.code = EXC_OV;
        else if (syscall_i)  sel_o.code = EXC_SYS;
        else if (break_i)    sel_o.code = EXC_BP;
        else if (eret_i)     sel_o.is_eret = 1'b1;
        else                 sel_o.valid = 1'b0;
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET commit controller: commit pulse, pipeline flush for a
// fixed number of cycles, then a held redirect to the handler or EPC.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        overflow_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic        delayslot_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic        redirect_ready_i,
    output logic        exc_commit_o,
    output logic [4:0]  exc_code_o,
    output logic        exc_delayslot_o,
    output logic [31:0] exc_pc_o,
    output logic        eret_commit_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    // state    | meaning
    // IDLE     | waiting for a qualified MEM-stage event
    // FLUSH    | flush_o asserted, counter running down
    // REDIRECT | redirect_valid_o held until fetch accepts
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic        exc_commit_q, exc_commit_d;
    logic        eret_commit_q, eret_commit_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic        exc_ds_q, exc_ds_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        flush_q, flush_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [7:0]  irq_lines;
    logic        irq_take;
    exc_sel_t    sel;
    logic        unused_status_cause;

    assign irq_lines = {int_i[5] | timer_int_i, int_i[4:0], cause_i[CAUSE_IP_HI:CAUSE_IP_LO]};
    assign irq_take  = mem_valid_i && status_i[STATUS_IE] && !status_i[STATUS_EXL]
                       && |(irq_lines & status_i[STATUS_IM_HI:STATUS_IM_LO]);
    assign unused_status_cause = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

    exc_prio_enc u_prio (
        .int_take_i (irq_take),
        .adel_i     (adel_i     & mem_valid_i),
        .ades_i     (ades_i     & mem_valid_i),
        .overflow_i (overflow_i & mem_valid_i),
        .syscall_i  (syscall_i  & mem_valid_i),
        .break_i    (break_i    & mem_valid_i),
        .eret_i     (eret_i     & mem_valid_i),
        .sel_o      (sel)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        target_d      = target_q;
        exc_commit_d  = 1'b0;
        eret_commit_d = 1'b0;
        exc_code_d    = exc_code_q;
        exc_ds_d      = exc_ds_q;
        exc_pc_d      = exc_pc_q;
        flush_d       = 1'b0;
        redir_valid_d = 1'b0;
        redir_pc_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (sel.valid) begin
                    state_d       = FLUSH;
                    cnt_d         = CNT_INIT;
                    target_d      = sel.is_eret ? epc_i : EXC_VECTOR;
                    exc_commit_d  = !sel.is_eret;
                    eret_commit_d = sel.is_eret;
                    exc_code_d    = sel.code;
                    exc_ds_d      = delayslot_i;
                    exc_pc_d      = exc_record_pc(pc_i, delayslot_i);
                    flush_d       = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d       = REDIRECT;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = target_q;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            REDIRECT: begin
                if (redirect_ready_i) begin
                    state_d = IDLE;
                end else begin
                    redir_valid_d = 1'b1;
                    redir_pc_d    = target_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            target_q      <= '0;
            exc_commit_q  <= 1'b0;
            eret_commit_q <= 1'b0;
            exc_code_q    <= '0;
            exc_ds_q      <= 1'b0;
            exc_pc_q      <= '0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            exc_commit_q  <= exc_commit_d;
            eret_commit_q <= eret_commit_d;
            exc_code_q    <= exc_code_d;
            exc_ds_q      <= exc_ds_d;
            exc_pc_q      <= exc_pc_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign exc_commit_o     = exc_commit_q;
    assign eret_commit_o    = eret_commit_q;
    assign exc_code_o       = exc_code_q;
    assign exc_delayslot_o  = exc_ds_q;
    assign exc_pc_o         = exc_pc_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios followed by random
// events checked against a cycle-timeline model of commit/flush/redirect.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int          FC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, syscall_i, break_i, overflow_i, adel_i, ades_i, eret_i;
    logic        delayslot_i, timer_int_i, redirect_ready_i;
    logic [31:0] pc_i, status_i, cause_i, epc_i;
    logic [5:0]  int_i;
    logic        exc_commit_o, exc_delayslot_o, eret_commit_o, flush_o, busy_o, redirect_valid_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_pc_o, redirect_pc_o;

    int n_cmp  = 0;
    int n_fail = 0;

    exc_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid_i      (mem_valid_i),
        .syscall_i        (syscall_i),
        .break_i          (break_i),
        .overflow_i       (overflow_i),
        .adel_i           (adel_i),
        .ades_i           (ades_i),
        .eret_i           (eret_i),
        .delayslot_i      (delayslot_i),
        .pc_i             (pc_i),
        .status_i         (status_i),
        .cause_i          (cause_i),
        .epc_i            (epc_i),
        .int_i            (int_i),
        .timer_int_i      (timer_int_i),
        .redirect_ready_i (redirect_ready_i),
        .exc_commit_o     (exc_commit_o),
        .exc_code_o       (exc_code_o),
        .exc_delayslot_o  (exc_delayslot_o),
        .exc_pc_o         (exc_pc_o),
        .eret_commit_o    (eret_commit_o),
        .flush_o          (flush_o),
        .busy_o           (busy_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {exc_commit, eret_commit, flush, redirect_valid, busy}
    function automatic logic [31:0] ctl();
        return {27'd0, exc_commit_o, eret_commit_o, flush_o, redirect_valid_o, busy_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_evt();
        mem_valid_i = 1'b0; syscall_i = 1'b0; break_i = 1'b0; overflow_i = 1'b0;
        adel_i = 1'b0; ades_i = 1'b0; eret_i = 1'b0; delayslot_i = 1'b0;
        timer_int_i = 1'b0; int_i = '0; status_i = '0; cause_i = '0; pc_i = '0;
    endtask

    task automatic drive_noise(input bit noise);
        if (noise) begin
            mem_valid_i = 1'b1;
            break_i     = 1'($urandom);
            syscall_i   = 1'($urandom);
            eret_i      = 1'($urandom);
            pc_i        = $urandom;
        end
    endtask

    // Returns {valid, is_eret, code} from the architectural priority rules.
    function automatic logic [6:0] ref_pick();
        logic [7:0] lines;
        bit pend = 0;
        lines = {int_i[5] | timer_int_i, int_i[4:0], cause_i[9:8]};
        for (int i = 0; i < 8; i++)
            if (lines[i] && status_i[8 + i]) pend = 1;
        if (!mem_valid_i)                        return 7'd0;
        if (pend && status_i[0] && !status_i[1]) return {2'b10, 5'd0};
        if (adel_i)                              return {2'b10, 5'd4};
        if (ades_i)                              return {2'b10, 5'd5};
        if (overflow_i)                          return {2'b10, 5'd12};
        if (syscall_i)                           return {2'b10, 5'd8};
        if (break_i)                             return {2'b10, 5'd9};
        if (eret_i)                              return {2'b11, 5'd0};
        return 7'd0;
    endfunction

    // Event inputs must already be driven; walks the whole transaction timeline.
    task automatic run_txn(input string tag, input logic is_eret, input logic [4:0] code,
                           input logic [31:0] rec_pc, input logic ds, input logic [31:0] tgt,
                           input int rdly, input bit noise);
        tick();
        clear_evt();
        drive_noise(noise);
        check({tag, ".ctl1"}, ctl(), {27'd0, !is_eret, is_eret, 3'b101});
        if (!is_eret) begin
            check({tag, ".code"}, {27'd0, exc_code_o}, {27'd0, code});
            check({tag, ".ds"},   {31'd0, exc_delayslot_o}, {31'd0, ds});
            check({tag, ".pc"},   exc_pc_o, rec_pc);
        end
        for (int k = 1; k < FC; k++) begin
            tick();
            drive_noise(noise);
            check({tag, ".flush"}, ctl(), 32'b00101);
        end
        for (int d = 0; d <= rdly; d++) begin
            tick();
            drive_noise(noise);
            check({tag, ".redir"},  ctl(), 32'b00011);
            check({tag, ".rpc"},    redirect_pc_o, tgt);
            redirect_ready_i = (d == rdly);
        end
        tick();
        redirect_ready_i = 1'b0;
        clear_evt();
        check({tag, ".done"}, ctl(), 32'd0);
    endtask

    initial begin
        logic [6:0]  exp;
        logic [31:0] rpc;
        rst = 1'b1;
        epc_i = '0;
        redirect_ready_i = 1'b0;
        clear_evt();
        tick();
        tick();
        check("rst.ctl",  ctl(), 32'd0);
        check("rst.rpc",  redirect_pc_o, 32'd0);
        check("rst.epc",  exc_pc_o, 32'd0);
        check("rst.code", {27'd0, exc_code_o}, 32'd0);
        rst = 1'b0;

        // Plain syscall
        mem_valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'h80001000;
        run_txn("sys", 1'b0, 5'd8, 32'h80001000, 1'b0, VEC, 0, 0);

        // Overflow in delay slot
        mem_valid_i = 1'b1; overflow_i = 1'b1; delayslot_i = 1'b1; pc_i = 32'h80002004;
        run_txn("ov_ds", 1'b0, 5'd12, 32'h80002000, 1'b1, VEC, 1, 0);

        // Delay slot at PC 2 wraps modulo 2^32
        mem_valid_i = 1'b1; adel_i = 1'b1; delayslot_i = 1'b1; pc_i = 32'h00000002;
        run_txn("wrap", 1'b0, 5'd4, 32'hFFFFFFFE, 1'b1, VEC, 0, 0);

        // Timer interrupt beats overflow; with EXL set overflow wins
        mem_valid_i = 1'b1; status_i = 32'h0000FF01; timer_int_i = 1'b1; overflow_i = 1'b1;
        pc_i = 32'h80004000;
        run_txn("irq", 1'b0, 5'd0, 32'h80004000, 1'b0, VEC, 0, 0);
        mem_valid_i = 1'b1; status_i = 32'h0000FF03; timer_int_i = 1'b1; overflow_i = 1'b1;
        pc_i = 32'h80004000;
        run_txn("exl", 1'b0, 5'd12, 32'h80004000, 1'b0, VEC, 0, 0);

        // ERET with fetch stalling three cycles
        epc_i = 32'h80003008;
        mem_valid_i = 1'b1; eret_i = 1'b1;
        run_txn("eret", 1'b1, 5'd0, 32'd0, 1'b0, 32'h80003008, 3, 0);

        // ERET together with break: exception wins
        mem_valid_i = 1'b1; eret_i = 1'b1; break_i = 1'b1; pc_i = 32'h80005010;
        run_txn("eret_bp", 1'b0, 5'd9, 32'h80005010, 1'b0, VEC, 0, 0);

        // Events while busy are ignored
        mem_valid_i = 1'b1; ades_i = 1'b1; pc_i = 32'h80006000;
        run_txn("busy_ign", 1'b0, 5'd5, 32'h80006000, 1'b0, VEC, 2, 1);

        // Flags without mem_valid, and masked interrupt with IE=0
        syscall_i = 1'b1; break_i = 1'b1;
        tick();
        check("nv.ctl", ctl(), 32'd0);
        clear_evt();
        mem_valid_i = 1'b1; status_i = 32'h0000FF00; int_i = 6'h3F;
        tick();
        check("ie0.ctl", ctl(), 32'd0);
        clear_evt();

        // Reset during REDIRECT
        mem_valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'h80007000;
        tick();
        clear_evt();
        for (int k = 0; k < FC; k++) tick();
        check("rr.pre", ctl(), 32'b00011);
        rst = 1'b1;
        tick();
        check("rr.ctl", ctl(), 32'd0);
        check("rr.rpc", redirect_pc_o, 32'd0);
        check("rr.epc", exc_pc_o, 32'd0);
        rst = 1'b0;
        tick();
        check("rr.after", ctl(), 32'd0);

        // Reset mid-flush
        mem_valid_i = 1'b1; break_i = 1'b1; pc_i = 32'h80008000;
        tick();
        clear_evt();
        rst = 1'b1;
        tick();
        check("rf.ctl", ctl(), 32'd0);
        rst = 1'b0;
        tick();
        check("rf.after", ctl(), 32'd0);

        // Randomized events against the reference rules
        for (int t = 0; t < 60; t++) begin
            mem_valid_i = ($urandom % 8) != 0;
            syscall_i   = ($urandom % 6) == 0;
            break_i     = ($urandom % 6) == 0;
            overflow_i  = ($urandom % 6) == 0;
            adel_i      = ($urandom % 8) == 0;
            ades_i      = ($urandom % 8) == 0;
            eret_i      = ($urandom % 5) == 0;
            status_i    = {16'd0, 8'($urandom), 6'd0, 2'($urandom)};
            cause_i     = $urandom;
            int_i       = ($urandom % 3 == 0) ? 6'($urandom) : 6'd0;
            timer_int_i = ($urandom % 4) == 0;
            delayslot_i = 1'($urandom);
            pc_i        = ($urandom % 8 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            epc_i       = $urandom;
            exp = ref_pick();
            rpc = delayslot_i ? pc_i - 32'd4 : pc_i;
            if (exp[6])
                run_txn("rnd", exp[5], exp[4:0], rpc, delayslot_i, exp[5] ? epc_i : VEC,
                        int'($urandom_range(0, 3)), bit'($urandom % 2));
            else begin
                tick();
                clear_evt();
                check("rnd.idle", ctl(), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
